// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, field positions, constants and ExcCodes.
// Optional timer support is enabled by defining CP0_TIMER_EN.
package cp0_pkg;

  localparam logic [4:0] SEL_COUNT   = 5'd9;
  localparam logic [4:0] SEL_COMPARE = 5'd11;
  localparam logic [4:0] SEL_SR      = 5'd12;
  localparam logic [4:0] SEL_CAUSE   = 5'd13;
  localparam logic [4:0] SEL_EPC     = 5'd14;
  localparam logic [4:0] SEL_PRID    = 5'd15;

  localparam int SR_IE         = 0;
  localparam int SR_EXL        = 1;
  localparam int SR_IM_LSB     = 10;
  localparam int SR_IM_MSB     = 15;
  localparam int CAUSE_BD      = 31;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_IP_MSB  = 15;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_EXC_MSB = 6;

  localparam logic [31:0] PRID_VALUE = 32'h4C41_0001;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with a sticky match flag (TI) cleared by any Compare write.
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      count <= count + 32'd1;
      if (compare_we) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (count == compare) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_wb.sv
// Write-back stage CP0: SR/Cause/EPC/PRId, exception/interrupt arbitration, ERET, MTC0.
// Define CP0_TIMER_EN to add Count(9)/Compare(11) and the timer interrupt on IP[15].
module cp0_wb
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] PC_in,
  input  logic        exc_in,
  input  logic [6:2]  ExcCode_in,
  input  logic        BD_in,
  input  logic        eret_in,
  input  logic        mtc0_in,
  input  logic [4:0]  sel,
  input  logic [31:0] wdata,
  input  logic [5:0]  hw_int,
  output logic [31:0] rdata,
  output logic        exc_req,
  output logic [31:2] epc_out,
  output logic [31:2] exc_vec
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip_q;
  logic [4:0]  exc_code;
  logic [31:2] epc;

  logic [5:0]  ip;
  logic        int_req;
  logic        wr_en;
  logic        ti;
  logic [31:0] count;
  logic [31:0] compare;

  // Writes only land when no exception is taken in the same cycle.
  assign wr_en = mtc0_in & ~exc_req & ~eret_in;

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .compare_we (wr_en && sel == SEL_COMPARE),
    .wdata      (wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );
`else
  assign ti      = 1'b0;
  assign count   = '0;
  assign compare = '0;
`endif

  assign ip      = {ip_q[5] | ti, ip_q[4:0]};
  assign int_req = (|(ip & im)) & ie & ~exl;
  // Gated by reset so the pipeline is never flushed while state is being cleared.
  assign exc_req = ~reset & (int_req | (exc_in & ~exl));
  assign epc_out = epc;
  assign exc_vec = EXC_VECTOR[31:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip_q     <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip_q <= hw_int;
      if (exc_req) begin
        exl      <= 1'b1;
        bd       <= BD_in;
        epc      <= BD_in ? PC_in - 30'd1 : PC_in;
        exc_code <= int_req ? EXC_INT : ExcCode_in;
      end else if (eret_in) begin
        exl <= 1'b0;
      end else if (wr_en) begin
        if (sel == SEL_SR) begin
          im  <= wdata[SR_IM_MSB:SR_IM_LSB];
          exl <= wdata[SR_EXL];
          ie  <= wdata[SR_IE];
        end else if (sel == SEL_EPC) begin
          epc <= wdata[31:2];
        end
      end
    end
  end

  // NOTE: rdata defaults to 0 before the case so no path infers a latch.
  always_comb begin
    rdata = '0;
    case (sel)
      SEL_SR: begin
        rdata[SR_IM_MSB:SR_IM_LSB] = im;
        rdata[SR_EXL]              = exl;
        rdata[SR_IE]               = ie;
      end
      SEL_CAUSE: begin
        rdata[CAUSE_BD]                        = bd;
        rdata[CAUSE_IP_MSB:CAUSE_IP_LSB]       = ip;
        rdata[CAUSE_EXC_MSB:CAUSE_EXC_LSB]     = exc_code;
      end
      SEL_EPC:     rdata = {epc, 2'b00};
      SEL_PRID:    rdata = PRID_VALUE;
      SEL_COUNT:   rdata = count;
      SEL_COMPARE: rdata = compare;
      default:     rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_wb.sv
// Directed, table-driven bench for cp0_wb; timer checks compile in under CP0_TIMER_EN.
module tb_cp0_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:2] PC_in;
  logic        exc_in;
  logic [6:2]  ExcCode_in;
  logic        BD_in;
  logic        eret_in;
  logic        mtc0_in;
  logic [4:0]  sel;
  logic [31:0] wdata;
  logic [5:0]  hw_int;
  logic [31:0] rdata;
  logic        exc_req;
  logic [31:2] epc_out;
  logic [31:2] exc_vec;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cp0_wb dut (
    .clk        (clk),
    .reset      (reset),
    .PC_in      (PC_in),
    .exc_in     (exc_in),
    .ExcCode_in (ExcCode_in),
    .BD_in      (BD_in),
    .eret_in    (eret_in),
    .mtc0_in    (mtc0_in),
    .sel        (sel),
    .wdata      (wdata),
    .hw_int     (hw_int),
    .rdata      (rdata),
    .exc_req    (exc_req),
    .epc_out    (epc_out),
    .exc_vec    (exc_vec)
  );

  typedef struct {
    logic        mtc0;
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic        exc;
    logic [4:0]  code;
    logic        bd;
    logic [29:0] pc;
    logic        eret;
    logic [5:0]  hw;
    logic        exp_req;
    logic [4:0]  rsel;
    logic [31:0] exp_rd;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic mtc0, input logic [4:0] wsel, input logic [31:0] wdat,
                              input logic exc, input logic [4:0] code, input logic bd,
                              input logic [29:0] pc, input logic eret, input logic [5:0] hw,
                              input logic exp_req, input logic [4:0] rsel, input logic [31:0] exp_rd);
    vec_t v;
    v.mtc0 = mtc0; v.wsel = wsel; v.wdat = wdat; v.exc = exc; v.code = code; v.bd = bd;
    v.pc = pc; v.eret = eret; v.hw = hw; v.exp_req = exp_req; v.rsel = rsel; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    exc_in = 1'b0; ExcCode_in = '0; BD_in = 1'b0; eret_in = 1'b0;
    mtc0_in = 1'b0; wdata = '0;
  endtask

  task automatic mtc0(input logic [4:0] s, input logic [31:0] d);
    @(negedge clk);
    idle();
    mtc0_in = 1'b1; sel = s; wdata = d;
    @(posedge clk);
    #1 idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;

    // mtc0 wsel wdata exc code bd pc eret hw | exp_req rsel exp_rdata
    vecs[0]  = mk(0, 0,  0,            0, 0,  0, 30'h0,   0, 6'h00, 0, 12, 32'h0000_0000);
    vecs[1]  = mk(0, 0,  0,            0, 0,  0, 30'h0,   0, 6'h00, 0, 13, 32'h0000_0000);
    vecs[2]  = mk(0, 0,  0,            0, 0,  0, 30'h0,   0, 6'h00, 0, 14, 32'h0000_0000);
    vecs[3]  = mk(0, 0,  0,            0, 0,  0, 30'h0,   0, 6'h00, 0, 15, 32'h4C41_0001);
    vecs[4]  = mk(1, 12, 32'hFFFF_FC01, 0, 0,  0, 30'h0,   0, 6'h00, 0, 12, 32'h0000_FC01);
    vecs[5]  = mk(0, 0,  0,            0, 0,  0, 30'h200, 0, 6'h01, 0, 13, 32'h0000_0400);
    vecs[6]  = mk(0, 0,  0,            0, 0,  0, 30'h200, 0, 6'h01, 1, 12, 32'h0000_FC03);
    vecs[7]  = mk(0, 0,  0,            0, 0,  0, 30'h0,   0, 6'h00, 0, 14, 32'h0000_0800);
    vecs[8]  = mk(0, 0,  0,            0, 0,  0, 30'h0,   1, 6'h00, 0, 12, 32'h0000_FC01);
    vecs[9]  = mk(0, 0,  0,            1, 12, 1, 30'h100, 0, 6'h00, 1, 13, 32'h8000_0030);
    vecs[10] = mk(0, 0,  0,            0, 0,  0, 30'h0,   0, 6'h00, 0, 14, 32'h0000_03FC);
    vecs[11] = mk(1, 14, 32'h0000_1234, 1, 4,  0, 30'h50,  0, 6'h00, 0, 14, 32'h0000_1234);
    vecs[12] = mk(0, 0,  0,            0, 0,  0, 30'h0,   1, 6'h00, 0, 12, 32'h0000_FC01);
    vecs[13] = mk(0, 0,  0,            0, 0,  0, 30'h0,   0, 6'h02, 0, 13, 32'h8000_0830);
    vecs[14] = mk(1, 12, 32'h0000_0000, 1, 10, 0, 30'h300, 0, 6'h02, 1, 12, 32'h0000_FC03);
    vecs[15] = mk(0, 0,  0,            0, 0,  0, 30'h0,   0, 6'h00, 0, 13, 32'h0000_0000);
    vecs[16] = mk(1, 13, 32'hFFFF_FFFF, 0, 0,  0, 30'h0,   0, 6'h00, 0, 13, 32'h0000_0000);
    vecs[17] = mk(1, 20, 32'hFFFF_FFFF, 0, 0,  0, 30'h0,   0, 6'h00, 0, 20, 32'h0000_0000);
    vecs[18] = mk(1, 14, 32'hFFFF_FFFF, 0, 0,  0, 30'h0,   0, 6'h00, 0, 14, 32'hFFFF_FFFC);
    vecs[19] = mk(0, 0,  0,            0, 0,  0, 30'h0,   1, 6'h00, 0, 12, 32'h0000_FC01);
    vecs[20] = mk(0, 0,  0,            1, 5,  1, 30'h0,   0, 6'h00, 1, 13, 32'h8000_0014);

    idle();
    reset = 1'b1; sel = '0; PC_in = '0; hw_int = '0;
    repeat (2) @(posedge clk);
    #1 check("exc_req during reset", {31'b0, exc_req}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("exc_vec", {exc_vec, 2'b00}, 32'h0000_4180);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      mtc0_in = vecs[i].mtc0; sel = vecs[i].wsel; wdata = vecs[i].wdat;
      exc_in = vecs[i].exc; ExcCode_in = vecs[i].code; BD_in = vecs[i].bd;
      PC_in = vecs[i].pc; eret_in = vecs[i].eret; hw_int = vecs[i].hw;
      #1 check($sformatf("vec%0d exc_req", i), {31'b0, exc_req}, {31'b0, vecs[i].exp_req});
      @(posedge clk);
      #1 idle();
      sel = vecs[i].rsel;
      #1 check($sformatf("vec%0d rdata sel%0d", i, vecs[i].rsel), rdata, vecs[i].exp_rd);
    end
    check("epc_out after delay-slot wrap", {2'b00, epc_out}, 32'h3FFF_FFFF);

    // Reset while EXL=1 with competing inputs, then interrupts pending but IE clear.
    @(negedge clk);
    reset = 1'b1; exc_in = 1'b1; ExcCode_in = 5'd12; hw_int = 6'h3F;
    mtc0_in = 1'b1; sel = 5'd12; wdata = 32'hFFFF_FFFF;
    #1 check("exc_req held low in reset", {31'b0, exc_req}, 32'h0);
    @(posedge clk);
    #1 idle();
    reset = 1'b0;
    sel = 5'd12; #1 check("SR after mid-exc reset", rdata, 32'h0);
    check("epc_out after reset", {epc_out, 2'b00}, 32'h0);
    sel = 5'd13; #1 check("Cause after mid-exc reset", rdata, 32'h0);
    repeat (3) begin
      @(posedge clk);
      #1 check("no interrupt while IE=0", {31'b0, exc_req}, 32'h0);
    end
    sel = 5'd13; #1 check("Cause.IP tracks hw_int", rdata, 32'h0000_FC00);
    @(negedge clk);
    hw_int = '0;

`ifdef CP0_TIMER_EN
    do_reset();
    mtc0(5'd11, 32'd5);
    mtc0(5'd12, 32'h0000_8001);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (exc_req) seen = 1'b1;
    end
    check("timer interrupt raised", {31'b0, seen}, 32'h1);
    @(posedge clk);
    #1 sel = 5'd13;
    #1 check("Cause.IP15 set by TI", rdata & 32'h0000_8000, 32'h0000_8000);
    mtc0(5'd11, 32'd1000);
    sel = 5'd13;
    #1 check("Compare write clears TI", rdata & 32'h0000_8000, 32'h0);
    sel = 5'd11;
    #1 check("Compare readback", rdata, 32'd1000);
`else
    seen = 1'b0;
    mtc0(5'd11, 32'd5);
    sel = 5'd11;
    #1 check("Compare absent reads 0", rdata, 32'h0);
    mtc0(5'd9, 32'd7);
    sel = 5'd9;
    #1 check("Count absent reads 0", rdata, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_wb.md
CP0_WB -- requirements
Module: cp0_wb

Interface
REQ-001 The block SHALL have ports: clk in 1, system clock; all state updates on rising edge.
REQ-002 The block SHALL have port reset in 1; synchronous, active-high.
REQ-003 The block SHALL have PC_in in [31:2], word PC of the instruction in WB.
REQ-004 The block SHALL have exc_in in 1, WB instruction carries an exception; ExcCode_in in [6:2], its code; BD_in in 1, the instruction sits in a delay slot.
REQ-005 The block SHALL have eret_in in 1 and mtc0_in in 1, the WB instruction is ERET / MTC0.
REQ-006 The block SHALL have sel in [4:0], the CP0 register index; wdata in [31:0], MTC0 data.
REQ-007 The block SHALL have hw_int in [5:0], external interrupt lines.
REQ-008 The block SHALL have rdata out [31:0], the CP0 register selected by sel.
REQ-009 The block SHALL have exc_req out 1, exception/interrupt taken this cycle; flushes the pipeline.
REQ-010 The block SHALL have epc_out out [31:2], current EPC; exc_vec out [31:2], handler address, constant 32'h0000_4180.

Function
REQ-011 Registers SHALL be: SR(12) = IM[15:10], EXL[1], IE[0], other bits read 0; Cause(13) = BD[31], IP[15:10], ExcCode[6:2], read-only to MTC0; EPC(14) = [31:2]; PRId(15) = constant 32'h4C41_0001, read-only.
REQ-012 Cause.IP SHALL register hw_int every cycle (1-cycle latency).
REQ-013 int_req SHALL be |(IP & IM) & IE & ~EXL, combinational.
REQ-014 exc_req SHALL be int_req | (exc_in & ~EXL), combinational, same cycle.
REQ-015 On a cycle with exc_req, the next edge SHALL set EXL=1, BD=BD_in, EPC=BD_in ? PC_in-1 : PC_in, ExcCode=int_req ? 0 : ExcCode_in.
REQ-016 Priority SHALL be interrupt > exc_in > eret_in > mtc0_in; lower-priority updates in an exc_req cycle are discarded.
REQ-017 eret_in without exc_req SHALL clear EXL at the next edge; epc_out is unaffected.
REQ-018 mtc0_in without exc_req SHALL write SR (masked fields) or EPC at the next edge; writes to other indices are ignored.
REQ-019 rdata SHALL be combinational from current state with no write bypass; unmapped sel returns 0.
REQ-020 exc_in while EXL=1 SHALL be ignored; there are no nested exceptions.

Reset
REQ-021 With reset high at an edge, SR, Cause, EPC and all internal state SHALL become 0, overriding every other input, including mid-exception.
REQ-022 During and after reset, exc_req SHALL be 0 until IE is set.

Configuration
REQ-023 With macro CP0_TIMER_EN defined, Count(9) SHALL increment every cycle and wrap at 2^32; Compare(11) is writable.
REQ-024 Under CP0_TIMER_EN, Count==Compare SHALL set timer-interrupt latch TI; an MTC0 write to Compare clears TI. IP[15] = hw_int[5] | TI. Both registers reset to 0.
REQ-025 Without CP0_TIMER_EN, indices 9 and 11 SHALL read 0 and ignore writes, and IP[15] = hw_int[5].

Structure
REQ-026 Shared package cp0_pkg SHALL hold register indices, SR/Cause field positions, the PRId value, the exception vector, and ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12).
REQ-027 Sub-module cp0_timer (Count/Compare/TI) SHALL be instantiated only under CP0_TIMER_EN.

Verification
REQ-028 Reset, then read sel 12/13/14/15 -> 0, 0, 0, 32'h4C41_0001; exc_req=0.
REQ-029 MTC0 SR=32'h0000_FC01, hw_int=6'b000001 -> exc_req=1 on the second cycle after the hw_int edge; next cycle Cause.ExcCode=0, EXL=1, EPC=PC_in.
REQ-030 exc_in=1, ExcCode_in=12, BD_in=1, PC_in=30'h100 -> exc_req=1 same cycle; next cycle EPC=30'h0FF, Cause=32'h8000_0030.
REQ-031 EXL=1 with exc_in plus mtc0_in to EPC -> exc_req=0 and EPC written; then eret_in -> EXL=0 next cycle.
REQ-032 Simultaneous interrupt and exc_in(ExcCode 10) -> ExcCode latched 0; a simultaneous mtc0 to SR is discarded.
REQ-033 With CP0_TIMER_EN, Compare=5 and IM[15]=IE=1 after reset -> exc_req asserts once Count reaches 5; writing Compare clears it.
